// File: rtl/cadence_meas.sv
// Pedal-cadence period meter: times rising edges of the filtered cadence level in prescaled ticks.
// Optional `define CADENCE_AVG_EN reports the mean of the last 4 periods instead of the raw one.
module cadence_meas #(
    parameter int FAST_SIM = 1,
    parameter int PRE_W    = 20,
    parameter int PER_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cadence_filt,
    output logic [PER_W-1:0] cadence_per,
    output logic             per_vld,
    output logic             not_pedaling
);

    localparam logic [PER_W-1:0] PER_MAX = '1;

    typedef enum logic [1:0] {
        STOPPED,
        ARMED,
        RUNNING
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             filt_ff;
    logic             rise;
    logic             tick;
    logic             sat;
    logic [PRE_W-1:0] pre_cnt;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] load_val;
    logic [PER_W-1:0] run_val;
    logic [PER_W-1:0] per_nx;
    logic             vld_nx;

    assign rise = cadence_filt & ~filt_ff;

    generate
        if (FAST_SIM != 0) begin : g_fast
            assign tick = &pre_cnt[9:0];
        end else begin : g_full
            assign tick = &pre_cnt;
        end
    endgenerate

    // rise masks sat so a pedal edge on the saturating tick still counts
    assign sat      = tick & (per_cnt == PER_MAX) & ~rise;
    assign load_val = (per_cnt == '0) ? PER_W'(1) : per_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_ff <= 1'b0;
            pre_cnt <= '0;
            per_cnt <= '0;
        end else begin
            filt_ff <= cadence_filt;
            pre_cnt <= rise ? '0 : pre_cnt + PRE_W'(1);
            if (rise) begin
                per_cnt <= '0;
            end else if (tick && per_cnt != PER_MAX) begin
                per_cnt <= per_cnt + PER_W'(1);
            end
        end
    end

`ifdef CADENCE_AVG_EN
    localparam int SUM_W = PER_W + 2;

    logic [PER_W-1:0] hist [4];
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_nx;
    logic             hist_pre;
    logic             hist_push;
    logic             hist_clr;

    assign hist_pre  = (state == ARMED) & rise;
    assign hist_push = (state == RUNNING) & rise;
    assign hist_clr  = (state_nx == STOPPED);
    assign sum_nx    = sum_q - SUM_W'(hist[3]) + SUM_W'(load_val);
    assign run_val   = sum_nx[SUM_W-1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            sum_q <= '0;
        end else if (hist_clr) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            sum_q <= '0;
        end else if (hist_pre) begin
            for (int i = 0; i < 4; i++) hist[i] <= load_val;
            sum_q <= {load_val, 2'b00};
        end else if (hist_push) begin
            hist[3] <= hist[2];
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= load_val;
            sum_q   <= sum_nx;
        end
    end
`else
    assign run_val = load_val;
`endif

    always_comb begin
        state_nx = state;
        per_nx   = cadence_per;
        vld_nx   = 1'b0;
        unique case (state)
            STOPPED: begin
                per_nx = PER_MAX;
                if (rise) state_nx = ARMED;
            end
            ARMED: begin
                if (rise) begin
                    state_nx = RUNNING;
                    per_nx   = load_val;
                    vld_nx   = 1'b1;
                end else if (sat) begin
                    state_nx = STOPPED;
                    per_nx   = PER_MAX;
                end
            end
            RUNNING: begin
                if (rise) begin
                    per_nx = run_val;
                    vld_nx = 1'b1;
                end else if (sat) begin
                    state_nx = STOPPED;
                    per_nx   = PER_MAX;
                end
            end
            default: begin
                state_nx = STOPPED;
                per_nx   = PER_MAX;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= STOPPED;
            cadence_per  <= PER_MAX;
            per_vld      <= 1'b0;
            not_pedaling <= 1'b1;
        end else begin
            state        <= state_nx;
            cadence_per  <= per_nx;
            per_vld      <= vld_nx;
            not_pedaling <= (state_nx != RUNNING);
        end
    end

endmodule

// File: tb/tb_cadence_meas.sv
// Self-checking bench for cadence_meas: directed scenarios plus randomized pedal gaps,
// checked against an edge-time reference model (periods from elapsed clocks between rises).
module tb_cadence_meas;

    localparam int PER_W    = 4;
    localparam int MAX      = (1 << PER_W) - 1;
    localparam int TICK     = 1024;
    localparam int SAT_SPAN = TICK * (MAX + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cadence_filt = 1'b0;
    logic [PER_W-1:0] cadence_per;
    logic             per_vld;
    logic             not_pedaling;

    cadence_meas #(
        .FAST_SIM(1),
        .PRE_W   (20),
        .PER_W   (PER_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cadence_filt(cadence_filt),
        .cadence_per (cadence_per),
        .per_vld     (per_vld),
        .not_pedaling(not_pedaling)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;

    // reference model: 0 stopped, 1 armed, 2 running
    int     m_state;
    longint t = 0;
    longint m_last = 0;
    int     m_per;
    bit     m_vld;
    bit     m_np;
    bit     prev_f;
    int     hist[$];
    int     m_vld_cnt = 0;
    int     d_vld_cnt = 0;

    task automatic m_reset();
        m_state = 0;
        m_per   = MAX;
        m_vld   = 1'b0;
        m_np    = 1'b1;
        prev_f  = 1'b0;
        hist.delete();
    endtask

    task automatic m_load(input int cap, input bit first);
        int s;
        s = 0;
`ifdef CADENCE_AVG_EN
        if (first) begin
            hist = '{cap, cap, cap, cap};
        end else begin
            void'(hist.pop_front());
            hist.push_back(cap);
        end
        foreach (hist[i]) s += hist[i];
        m_per = s / 4;
`else
        m_per = cap;
`endif
    endtask

    task automatic model_edge(input bit f);
        bit     r;
        longint g;
        int     cap;
        r      = f & ~prev_f;
        prev_f = f;
        t++;
        m_vld  = 1'b0;
        if (r) begin
            g   = t - m_last;
            cap = ((g - 1) / TICK > MAX) ? MAX : int'((g - 1) / TICK);
            if (cap == 0) cap = 1;
            m_last = t;
            if (m_state == 0) begin
                m_state = 1;
            end else begin
                m_load(cap, m_state == 1);
                m_state = 2;
                m_vld   = 1'b1;
                m_np    = 1'b0;
            end
        end else if (m_state != 0 && t - m_last == SAT_SPAN) begin
            m_state = 0;
            m_per   = MAX;
            m_np    = 1'b1;
            hist.delete();
        end
    endtask

    task automatic cyc(input bit f);
        cadence_filt = f;
        @(posedge clk);
        model_edge(f);
        @(negedge clk);
        if (per_vld) d_vld_cnt++;
        if (m_vld) m_vld_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0);
    endtask

    task automatic first_rise();
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic next_rise(input int gap, input int hi);
        for (int i = 1; i < gap; i++) cyc(i < hi);
        cyc(1'b1);
    endtask

    task automatic test_reset();
        m_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(MAX), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_hold: got per=%0d vld=%b np=%b want per=%0d vld=0 np=1",
                     cadence_per, per_vld, not_pedaling, MAX);
        end
        rst_n = 1'b1;
        idle(5000);
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(MAX), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_idle: got per=%0d vld=%b np=%b want per=%0d vld=0 np=1",
                     cadence_per, per_vld, not_pedaling, MAX);
        end
    endtask

    task automatic test_first_periods();
        first_rise();
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL arm_rise: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
        next_rise(10240 + $urandom_range(1, 1000), $urandom_range(1, 4000));
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(10), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL first_load: got per=%0d vld=%b np=%b want per=10 vld=1 np=0",
                     cadence_per, per_vld, not_pedaling);
        end
        cyc(1'b0);
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL vld_pulse: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
    endtask

    task automatic test_reset_mid();
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(MAX), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: got per=%0d vld=%b np=%b want per=%0d vld=0 np=1",
                     cadence_per, per_vld, not_pedaling, MAX);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        first_rise();
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL rearm_rise: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
        next_rise(10240 + $urandom_range(1, 1000), $urandom_range(1, 4000));
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(10), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reload_after_rst: got per=%0d vld=%b np=%b want per=10 vld=1 np=0",
                     cadence_per, per_vld, not_pedaling);
        end
    endtask

    task automatic test_rate_change();
        int want;
`ifdef CADENCE_AVG_EN
        want = 8;
`else
        want = 5;
`endif
        next_rise(5120 + $urandom_range(1, 1000), $urandom_range(1, 2000));
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(want), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL rate_change: got per=%0d vld=%b np=%b want per=%0d vld=1 np=0",
                     cadence_per, per_vld, not_pedaling, want);
        end
    endtask

    task automatic test_stop();
        idle(SAT_SPAN - 1);
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL pre_sat: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
        cyc(1'b0);
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(MAX), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL sat_stop: got per=%0d vld=%b np=%b want per=%0d vld=0 np=1",
                     cadence_per, per_vld, not_pedaling, MAX);
        end
        first_rise();
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(MAX), 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL restart_arm: got per=%0d vld=%b np=%b want per=%0d vld=0 np=1",
                     cadence_per, per_vld, not_pedaling, MAX);
        end
        next_rise(2048 + $urandom_range(1, 1000), $urandom_range(1, 1000));
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL restart_load: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
    endtask

    task automatic test_sat_race();
        next_rise(SAT_SPAN, $urandom_range(1, 1000));
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL sat_race: got per=%0d vld=%b np=%b want per=%0d vld=1 np=0",
                     cadence_per, per_vld, not_pedaling, m_per);
        end
`ifndef CADENCE_AVG_EN
        vectors++;
        if (cadence_per !== PER_W'(MAX)) begin
            miscompares++;
            $display("FAIL sat_race_per: got per=%0d want per=%0d", cadence_per, MAX);
        end
`endif
        cyc(1'b0);
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL sat_race_hold: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
    endtask

    task automatic test_back_to_back();
        next_rise(2, 1);
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL b2b_gap2: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
        next_rise(TICK, $urandom_range(1, TICK - 1));
        vectors++;
        if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
            miscompares++;
            $display("FAIL b2b_tick_edge: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                     cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
        end
    endtask

    task automatic test_random();
        int gap;
        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 3) == 0) gap = TICK * $urandom_range(1, 2);
            else gap = $urandom_range(2, 2500);
            next_rise(gap, $urandom_range(1, gap - 1));
            vectors++;
            if ({cadence_per, per_vld, not_pedaling} !== {PER_W'(m_per), m_vld, m_np}) begin
                miscompares++;
                $display("FAIL rand_%0d gap=%0d: got per=%0d vld=%b np=%b want per=%0d vld=%b np=%b",
                         n, gap, cadence_per, per_vld, not_pedaling, m_per, m_vld, m_np);
            end
        end
        cyc(1'b0);
        vectors++;
        if (d_vld_cnt !== m_vld_cnt) begin
            miscompares++;
            $display("FAIL vld_count: got %0d pulses want %0d", d_vld_cnt, m_vld_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_first_periods();
        test_reset_mid();
        test_rate_change();
        test_stop();
        test_sat_race();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
